// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// The mem_in/mem_out records mirror the CPU-side memory bus fields one-to-one.
package memory_arbiter_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_type;

  typedef struct packed {
    arb_state_type state;
    mem_in_type    req;
    logic [3:0]    starve_cnt;
  } arb_reg_type;

  localparam arb_reg_type ARB_REG_INIT = '{state: IDLE, req: '0, starve_cnt: 4'd0};

endpackage

// File: rtl/memory_arbiter.sv
// Two-requester arbiter (fetch vs load/store) in front of a single memory port.
// Data wins ties unless the fetch side has waited through STARVE_LIMIT data grants.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  memory_in,
  input  mem_out_type memory_out,
  output arb_reg_type dbg_reg
);

  // Handshake: a requester holds mem_valid until it sees mem_ready for one cycle;
  // the memory holds ready low until it completes, and completes only while
  // memory_in.mem_valid is high. Every transaction is followed by an IDLE cycle.
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_reg_type r_q;
  arb_reg_type r_d;
  logic        instr_wins;

  always_comb begin
    r_d        = r_q;
    imem_out   = '0;
    dmem_out   = '0;
    instr_wins = imem_in.mem_valid && (!dmem_in.mem_valid || (r_q.starve_cnt == LIMIT));

    case (r_q.state)
      IDLE: begin
        if (!imem_in.mem_valid) begin
          r_d.starve_cnt = '0;
        end
        if (instr_wins) begin
          r_d.req           = imem_in;
          r_d.req.mem_valid = 1'b1;
          r_d.req.mem_instr = 1'b1;
          r_d.req.mem_wstrb = '0;
          r_d.state         = BUSY_I;
          r_d.starve_cnt    = '0;
        end else if (dmem_in.mem_valid) begin
          r_d.req           = dmem_in;
          r_d.req.mem_valid = 1'b1;
          r_d.req.mem_instr = 1'b0;
          r_d.state         = BUSY_D;
          // A fetch was passed over: count it, saturating at the limit.
          if (imem_in.mem_valid && (r_q.starve_cnt != LIMIT)) begin
            r_d.starve_cnt = r_q.starve_cnt + 4'd1;
          end
        end
      end
      BUSY_I: begin
        if (memory_out.mem_ready) begin
          imem_out          = memory_out;
          r_d.req.mem_valid = 1'b0;
          r_d.state         = IDLE;
        end
      end
      BUSY_D: begin
        if (memory_out.mem_ready) begin
          dmem_out          = memory_out;
          r_d.req.mem_valid = 1'b0;
          r_d.state         = IDLE;
        end
      end
      default: begin
        r_d = ARB_REG_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= ARB_REG_INIT;
    end else begin
      r_q <= r_d;
    end
  end

  assign memory_in = r_q.req;
  assign dbg_reg   = r_q;

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, 4, max consecutive data grants while an instruction request waits (range 1..15).
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: imem_in  in  mem_in_type  fetch request (mem_valid 1, mem_instr 1, mem_addr 32, mem_wdata 32, mem_wstrb 4).
REQ-005 SHALL have port: imem_out  out  mem_out_type  fetch response (mem_ready 1, mem_rdata 32).
REQ-006 SHALL have port: dmem_in  in  mem_in_type  load/store request from decode stage.
REQ-007 SHALL have port: dmem_out  out  mem_out_type  load/store response.
REQ-008 SHALL have port: memory_in  out  mem_in_type  request to the single shared memory port.
REQ-009 SHALL have port: memory_out  in  mem_out_type  response from the shared memory port.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY_I, BUSY_D.
REQ-011 In IDLE, with imem_in.mem_valid or dmem_in.mem_valid high, SHALL latch the winner's request into a request register and move to BUSY_I or BUSY_D.
REQ-012 Winner rule: data only -> data; instr only -> instr; both -> data, unless the starvation count equals STARVE_LIMIT, then instr.
REQ-013 memory_in SHALL be driven only from the request register, so memory sees the request one cycle after the requester asserts it.
REQ-014 Latched mem_instr SHALL be forced to 1 for instruction grants and 0 for data grants; mem_wstrb SHALL be forced to 0 for instruction grants.
REQ-015 In BUSY_x, memory_in.mem_valid SHALL stay 1 and the latched fields SHALL stay constant until memory_out.mem_ready=1.
REQ-016 Requester input changes during BUSY_x SHALL be ignored.
REQ-017 When memory_out.mem_ready=1 in BUSY_x: owner's mem_ready SHALL be 1 in that same cycle and its mem_rdata SHALL equal memory_out.mem_rdata (combinational).
REQ-018 In the same cycle as REQ-017, the request register valid SHALL clear and the next state SHALL be IDLE.
REQ-019 Non-owner mem_ready SHALL be 0 at all times; memory_out.mem_ready in IDLE SHALL be ignored.
REQ-020 Back-to-back grants are not allowed: at least one IDLE cycle SHALL separate transactions. Requesters drop or renew valid after seeing ready, so no duplicate issue occurs.
REQ-021 Starvation counter: width 4; increment (saturating at STARVE_LIMIT) on each data grant made while imem_in.mem_valid=1.
REQ-022 Starvation counter SHALL clear on any instruction grant, or in any IDLE cycle with imem_in.mem_valid=0.
REQ-023 Transaction latency: request cycle N -> memory valid N+1 -> response in the cycle memory asserts ready (earliest N+1).
REQ-024 mem_rdata to the non-owner, and to both requesters in IDLE, SHALL be 0.

Reset
REQ-025 On rst=0, immediately and independent of clk: state IDLE, request register all-zero (memory_in.mem_valid=0), starvation counter 0, imem_out/dmem_out all-zero.
REQ-026 Reset during BUSY_x SHALL abandon the transaction; no ready SHALL be delivered for it after reset release.
REQ-027 The first grant after reset release SHALL follow REQ-012 with counter 0.

Structure
REQ-028 Enum arb_state_type (IDLE, BUSY_I, BUSY_D) and constant init value for the arbiter register SHALL live in the shared constants/wires packages; mem_in_type/mem_out_type are reused unchanged.
REQ-029 Single module with a two-process (comb + ff) register style; no sub-module required.

Verification
REQ-030 Fetch only: imem valid addr 0x100, memory ready 2 cycles later with rdata 0x00000013 -> memory_in addr 0x100, instr=1, wstrb=0; imem_out ready pulse with 0x00000013; dmem_out ready stays 0.
REQ-031 Simultaneous requests: imem 0x200 and dmem store 0x8000 (wdata 0xDEADBEEF, wstrb 0xF) -> data issued first; instr issued after one IDLE cycle.
REQ-032 Starvation: STARVE_LIMIT=4, dmem valid every IDLE cycle, imem held -> 4 data grants, then instr grant, then counter 0.
REQ-033 Input churn: dmem addr changes 0x10 -> 0x20 while BUSY_D -> memory_in addr stays 0x10 until ready.
REQ-034 Reset mid-transaction: assert rst in BUSY_I -> memory_in.mem_valid=0 immediately; a later memory ready produces no imem_out ready.
REQ-035 Stray ready: memory_out.mem_ready=1 in IDLE -> both responses remain 0 and the state is unchanged.
